// File: rtl/fifo_param.sv
// Synchronous FIFO with a control FSM, programmable almost-empty/almost-full
// thresholds, registered read data and sticky overflow/underflow reporting.
module fifo_param #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FIFO_WORD_SIZE = 10,
    parameter int FIFO_PTR_SIZE  = $clog2(FIFO_DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic                      init,
    input  logic [FIFO_WORD_SIZE-1:0] data_in,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic [FIFO_PTR_SIZE-1:0]  almost_empty_threshold_input,
    input  logic [FIFO_PTR_SIZE-1:0]  almost_full_threshold_input,
    output logic [FIFO_WORD_SIZE-1:0] data_out,
    output logic                      valid,
    output logic                      empty_flag,
    output logic                      full_flag,
    output logic                      almost_empty_flag,
    output logic                      almost_full_flag,
    output logic                      error_flag,
    output logic [1:0]                error_code,
    output logic [FIFO_PTR_SIZE:0]    fill_level,
    output logic [2:0]                state
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam logic [FIFO_PTR_SIZE:0]   FULL_LEVEL = (FIFO_PTR_SIZE + 1)'(FIFO_DEPTH);
    localparam logic [FIFO_PTR_SIZE:0]   FILL_ONE   = (FIFO_PTR_SIZE + 1)'(1);
    localparam logic [FIFO_PTR_SIZE-1:0] PTR_ONE    = FIFO_PTR_SIZE'(1);

    state_t                     cur_state;
    state_t                     nxt_state;
    logic [FIFO_WORD_SIZE-1:0]  mem [FIFO_DEPTH];
    logic [FIFO_PTR_SIZE-1:0]   wr_ptr;
    logic [FIFO_PTR_SIZE-1:0]   rd_ptr;
    logic [FIFO_PTR_SIZE-1:0]   ae_thr;
    logic [FIFO_PTR_SIZE-1:0]   af_thr;
    logic [FIFO_PTR_SIZE:0]     fill_nxt;
    logic                       rd_acc;
    logic                       wr_acc;
    logic                       ovf;
    logic                       udf;

    assign state = cur_state;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_L)
            cur_state <= ST_RESET;
        else
            cur_state <= nxt_state;
    end

    // Transfer acceptance, error detection, next occupancy and next state
    always_comb begin
        nxt_state = cur_state;
        rd_acc    = 1'b0;
        wr_acc    = 1'b0;
        ovf       = 1'b0;
        udf       = 1'b0;
        fill_nxt  = fill_level;
        if (init) begin
            nxt_state = ST_INIT;
        end else begin
            case (cur_state)
                ST_RESET: nxt_state = ST_INIT;
                ST_INIT:  nxt_state = ST_IDLE;
                ST_IDLE, ST_ACTIVE: begin
                    rd_acc = rd_en && !empty_flag;
                    udf    = rd_en && empty_flag;
                    // A read in the same cycle frees a slot, so a full FIFO still accepts the write
                    wr_acc = wr_en && (!full_flag || rd_acc);
                    ovf    = wr_en && full_flag && !rd_acc;
                    if (wr_acc && !rd_acc)
                        fill_nxt = fill_level + FILL_ONE;
                    else if (rd_acc && !wr_acc)
                        fill_nxt = fill_level - FILL_ONE;
                    if (ovf || udf)
                        nxt_state = ST_ERROR;
                    else if (cur_state == ST_IDLE && wr_acc)
                        nxt_state = ST_ACTIVE;
                    else if (cur_state == ST_ACTIVE && fill_nxt == '0)
                        nxt_state = ST_IDLE;
                end
                ST_ERROR: nxt_state = ST_ERROR;
                default:  nxt_state = ST_RESET;
            endcase
        end
    end

    // Storage array; contents are not cleared, only the pointers are
    always_ff @(posedge clk) begin
        if (reset_L && wr_acc)
            mem[wr_ptr] <= data_in;
    end

    // Pointers, occupancy, flags, read data and error reporting
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            fill_level        <= '0;
            ae_thr            <= '0;
            af_thr            <= '0;
            data_out          <= '0;
            valid             <= 1'b0;
            empty_flag        <= 1'b1;
            full_flag         <= 1'b0;
            almost_empty_flag <= 1'b1;
            almost_full_flag  <= 1'b0;
            error_flag        <= 1'b0;
            error_code        <= '0;
        end else if (nxt_state == ST_INIT) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            fill_level        <= '0;
            ae_thr            <= almost_empty_threshold_input;
            af_thr            <= almost_full_threshold_input;
            valid             <= 1'b0;
            empty_flag        <= 1'b1;
            full_flag         <= 1'b0;
            // At zero occupancy: always <= AE threshold, never >= a nonzero AF threshold
            almost_empty_flag <= 1'b1;
            almost_full_flag  <= 1'b0;
            error_flag        <= 1'b0;
            error_code        <= '0;
        end else begin
            valid <= rd_acc;
            if (rd_acc) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PTR_ONE;
            end
            if (wr_acc)
                wr_ptr <= wr_ptr + PTR_ONE;
            fill_level        <= fill_nxt;
            empty_flag        <= (fill_nxt == '0);
            full_flag         <= (fill_nxt == FULL_LEVEL);
            almost_empty_flag <= (fill_nxt <= {1'b0, ae_thr});
            almost_full_flag  <= (af_thr != '0) && (fill_nxt >= {1'b0, af_thr});
            if (ovf) begin
                error_code[0] <= 1'b1;
                error_flag    <= 1'b1;
            end
            if (udf) begin
                error_code[1] <= 1'b1;
                error_flag    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       init;
    logic [9:0] data_in;
    logic       wr_en;
    logic       rd_en;
    logic [2:0] ae_in;
    logic [2:0] af_in;
    logic [9:0] data_out;
    logic       valid;
    logic       empty_flag;
    logic       full_flag;
    logic       almost_empty_flag;
    logic       almost_full_flag;
    logic       error_flag;
    logic [1:0] error_code;
    logic [3:0] fill_level;
    logic [2:0] state;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: mode 0..4 = RESET, INIT, IDLE, ACTIVE, ERROR
    int unsigned m_state = 0;
    logic [9:0]  m_q[$];
    logic [9:0]  m_dout = '0;
    logic        m_valid = 1'b0;
    logic [1:0]  m_err = '0;
    int unsigned m_ae = 0;
    int unsigned m_af = 0;

    fifo_param #(
        .FIFO_DEPTH(8),
        .FIFO_WORD_SIZE(10)
    ) dut (
        .clk(clk),
        .reset_L(reset_L),
        .init(init),
        .data_in(data_in),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .almost_empty_threshold_input(ae_in),
        .almost_full_threshold_input(af_in),
        .data_out(data_out),
        .valid(valid),
        .empty_flag(empty_flag),
        .full_flag(full_flag),
        .almost_empty_flag(almost_empty_flag),
        .almost_full_flag(almost_full_flag),
        .error_flag(error_flag),
        .error_code(error_code),
        .fill_level(fill_level),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Advance the model by one clock edge using the inputs presented to it
    task automatic model_step();
        bit full, emp, rd, wr;
        if (!reset_L) begin
            m_state = 0;
            m_q.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_err   = '0;
            m_ae    = 0;
            m_af    = 0;
        end else if (init || m_state == 0) begin
            m_state = 1;
            m_q.delete();
            m_valid = 1'b0;
            m_err   = '0;
            m_ae    = ae_in;
            m_af    = af_in;
        end else if (m_state == 1) begin
            m_state = 2;
            m_valid = 1'b0;
        end else if (m_state == 4) begin
            m_valid = 1'b0;
        end else begin
            full = (m_q.size() == 8);
            emp  = (m_q.size() == 0);
            rd   = rd_en && !emp;
            wr   = wr_en && (!full || rd);
            m_valid = rd;
            if (rd) m_dout = m_q.pop_front();
            if (wr) m_q.push_back(data_in);
            if (wr_en && full && !rd) m_err[0] = 1'b1;
            if (rd_en && emp) m_err[1] = 1'b1;
            if (m_err != '0)
                m_state = 4;
            else if (m_state == 2 && wr)
                m_state = 3;
            else if (m_state == 3 && m_q.size() == 0)
                m_state = 2;
        end
    endtask

    task automatic compare_all();
        int unsigned n;
        n = m_q.size();
        check("state", state, m_state);
        check("fill_level", fill_level, n);
        check("empty_flag", empty_flag, n == 0);
        check("full_flag", full_flag, n == 8);
        check("almost_empty_flag", almost_empty_flag, n <= m_ae);
        check("almost_full_flag", almost_full_flag, (m_af != 0) && (n >= m_af));
        check("error_flag", error_flag, m_err != '0);
        check("error_code", error_code, m_err);
        check("valid", valid, m_valid);
        check("data_out", data_out, m_dout);
    endtask

    // One clock: drive inputs away from the edge, update model at the edge, sample after
    task automatic cycle(input logic rst_l, input logic ini, input logic we,
                         input logic re, input logic [9:0] din);
        reset_L = rst_l;
        init    = ini;
        wr_en   = we;
        rd_en   = re;
        data_in = din;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        reset_L = 1'b0; init = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        data_in = '0; ae_in = 3'd0; af_in = 3'd0;
        #1;

        // Reset with noisy inputs, then INIT with AE=2 / AF=6
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 10'h155);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        check("reset_state", state, 0);
        check("reset_ae", almost_empty_flag, 1);
        ae_in = 3'd2; af_in = 3'd6;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 10'h000);
        check("init_state", state, 1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 10'h000);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        check("idle_state", state, 2);

        // Fill with 1..8
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 10'(i));
            check("af_ramp", almost_full_flag, i >= 6);
        end
        check("full_after_8", full_flag, 1);

        // Drain: 1..8 in order, each valid for one cycle
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 10'h000);
            check("drain_data", data_out, i);
            check("drain_valid", valid, 1);
        end
        check("drain_empty", empty_flag, 1);
        check("drain_idle", state, 2);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        check("valid_one_cycle", valid, 0);
        check("data_hold", data_out, 8);

        // Refill, then simultaneous read+write at full
        for (int i = 1; i <= 8; i++)
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 10'(i));
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 10'h009);
        check("rw_full_fill", fill_level, 8);
        check("rw_full_data", data_out, 10'h001);
        check("rw_full_noerr", error_flag, 0);

        // Overflow, held in ERROR, then recover with init
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 10'h0AA);
        check("ovf_code", error_code, 2'b01);
        check("ovf_state", state, 4);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 10'h0BB);
        check("err_hold_fill", fill_level, 8);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 10'h000);
        check("ovf_clear_state", state, 1);
        check("ovf_clear_fill", fill_level, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);

        // Underflow with a same-cycle write
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 10'h3FF);
        check("udf_code", error_code, 2'b10);
        check("udf_fill", fill_level, 1);
        check("udf_state", state, 4);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 10'h000);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);

        // Five writes then a one-cycle reset pulse
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 10'(10'h100 + i));
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 10'h123);
        check("rst_mid_state", state, 0);
        check("rst_mid_fill", fill_level, 0);
        check("rst_mid_dout", data_out, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        check("rst_to_init", state, 1);

        // Random traffic with alternating fill/drain bias
        for (int unsigned i = 0; i < 3000; i++) begin
            int unsigned wp;
            wp = ((i / 40) % 2 == 0) ? 80 : 25;
            ae_in = 3'($urandom_range(0, 7));
            af_in = 3'($urandom_range(0, 7));
            cycle(($urandom % 150) != 0,
                  ($urandom % 35) == 0,
                  ($urandom % 100) < wp,
                  ($urandom % 100) < (105 - wp),
                  10'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
